// File: rtl/div_ctrl_if.sv
// Handshake bundle between the execute stage, the multi-cycle divider and div_ctrl.
// master is the surrounding environment (execute stage + divider); slave is the controller.
interface div_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             in_signed_i;
    logic             in_rem_i;
    logic             in_word_i;
    logic [63:0]      in_src1_i;
    logic [63:0]      in_src2_i;
    logic [TAG_W-1:0] in_tag_i;

    logic             div_req_valid_o;
    logic             div_block_o;
    logic [63:0]      div_op_1_o;
    logic [63:0]      div_op_2_o;
    logic             div_sign_op_1_o;
    logic             div_sign_op_2_o;
    logic [63:0]      div_quotient_i;
    logic [63:0]      div_remainder_i;
    logic             div_valid_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [63:0]      out_result_o;
    logic [TAG_W-1:0] out_tag_o;

    modport master (
        output flush_i, in_valid_i, in_signed_i, in_rem_i, in_word_i,
               in_src1_i, in_src2_i, in_tag_i,
               div_quotient_i, div_remainder_i, div_valid_i, out_ready_i,
        input  in_ready_o, div_req_valid_o, div_block_o, div_op_1_o, div_op_2_o,
               div_sign_op_1_o, div_sign_op_2_o, out_valid_o, out_result_o, out_tag_o
    );

    modport slave (
        input  flush_i, in_valid_i, in_signed_i, in_rem_i, in_word_i,
               in_src1_i, in_src2_i, in_tag_i,
               div_quotient_i, div_remainder_i, div_valid_i, out_ready_i,
        output in_ready_o, div_req_valid_o, div_block_o, div_op_1_o, div_op_2_o,
               div_sign_op_1_o, div_sign_op_2_o, out_valid_o, out_result_o, out_tag_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencing controller for the 64-bit multi-cycle divider: resolves trivial cases and
// result reuse locally, otherwise issues to the divider and holds operands until it finishes.
module div_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               req_valid_q, req_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        op1_q, op1_d;
    logic [63:0]        op2_q, op2_d;
    logic               sign_q, sign_d;
    logic               rem_q, rem_d;
    logic               word_q, word_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [63:0]        result_q, result_d;

    logic               reuse_valid_q, reuse_valid_d;
    logic [63:0]        reuse_op1_q, reuse_op1_d;
    logic [63:0]        reuse_op2_q, reuse_op2_d;
    logic               reuse_sign_q, reuse_sign_d;
    logic               reuse_word_q, reuse_word_d;
    logic [63:0]        reuse_quot_q, reuse_quot_d;
    logic [63:0]        reuse_rem_q, reuse_rem_d;

    logic [63:0]        prep_op1, prep_op2, min_neg;
    logic [63:0]        spec_quot, spec_rem;
    logic               is_zero_div, is_overflow, is_reuse, accept;

    function automatic logic [63:0] select_result(input logic [63:0] q, input logic [63:0] r,
                                                  input logic rem, input logic word);
        logic [63:0] v;
        v = rem ? r : q;
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation and special-case detection on the incoming request
    always_comb begin
        prep_op1 = bus.in_src1_i;
        prep_op2 = bus.in_src2_i;
        if (bus.in_word_i) begin
            prep_op1 = {{32{bus.in_signed_i & bus.in_src1_i[31]}}, bus.in_src1_i[31:0]};
            prep_op2 = {{32{bus.in_signed_i & bus.in_src2_i[31]}}, bus.in_src2_i[31:0]};
        end
        min_neg     = bus.in_word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        is_zero_div = (prep_op2 == 64'd0);
        is_overflow = bus.in_signed_i && (prep_op1 == min_neg) && (prep_op2 == '1);
        is_reuse    = reuse_valid_q && (prep_op1 == reuse_op1_q) && (prep_op2 == reuse_op2_q)
                      && (bus.in_signed_i == reuse_sign_q) && (bus.in_word_i == reuse_word_q);
        accept      = bus.in_valid_i && in_ready_q && !bus.flush_i;
        if (is_zero_div) begin
            spec_quot = '1;
            spec_rem  = prep_op1;
        end else if (is_overflow) begin
            spec_quot = prep_op1;
            spec_rem  = 64'd0;
        end else begin
            spec_quot = reuse_quot_q;
            spec_rem  = reuse_rem_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        req_valid_d   = 1'b0;
        out_valid_d   = out_valid_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        sign_d        = sign_q;
        rem_d         = rem_q;
        word_d        = word_q;
        tag_d         = tag_q;
        result_d      = result_q;
        reuse_valid_d = reuse_valid_q;
        reuse_op1_d   = reuse_op1_q;
        reuse_op2_d   = reuse_op2_q;
        reuse_sign_d  = reuse_sign_q;
        reuse_word_d  = reuse_word_q;
        reuse_quot_d  = reuse_quot_q;
        reuse_rem_d   = reuse_rem_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op1_d      = prep_op1;
                    op2_d      = prep_op2;
                    sign_d     = bus.in_signed_i;
                    rem_d      = bus.in_rem_i;
                    word_d     = bus.in_word_i;
                    tag_d      = bus.in_tag_i;
                    in_ready_d = 1'b0;
                    if (is_zero_div || is_overflow || is_reuse) begin
                        result_d    = select_result(spec_quot, spec_rem, bus.in_rem_i, bus.in_word_i);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        req_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = bus.flush_i ? DRAIN : WAIT;
            end
            WAIT: begin
                if (bus.flush_i) begin
                    state_d = DRAIN;
                end else if (bus.div_valid_i) begin
                    reuse_valid_d = 1'b1;
                    reuse_op1_d   = op1_q;
                    reuse_op2_d   = op2_q;
                    reuse_sign_d  = sign_q;
                    reuse_word_d  = word_q;
                    reuse_quot_d  = bus.div_quotient_i;
                    reuse_rem_d   = bus.div_remainder_i;
                    result_d      = select_result(bus.div_quotient_i, bus.div_remainder_i,
                                                  rem_q, word_q);
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            // The divider cannot be aborted, so a flushed run is waited out with operands held
            DRAIN: begin
                if (bus.div_valid_i) begin
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            DONE: begin
                if (bus.flush_i || bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase

        if (bus.flush_i) begin
            reuse_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b1;
            req_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            op1_q         <= 64'd0;
            op2_q         <= 64'd0;
            sign_q        <= 1'b0;
            rem_q         <= 1'b0;
            word_q        <= 1'b0;
            tag_q         <= '0;
            result_q      <= 64'd0;
            reuse_valid_q <= 1'b0;
            reuse_op1_q   <= 64'd0;
            reuse_op2_q   <= 64'd0;
            reuse_sign_q  <= 1'b0;
            reuse_word_q  <= 1'b0;
            reuse_quot_q  <= 64'd0;
            reuse_rem_q   <= 64'd0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            req_valid_q   <= req_valid_d;
            out_valid_q   <= out_valid_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            sign_q        <= sign_d;
            rem_q         <= rem_d;
            word_q        <= word_d;
            tag_q         <= tag_d;
            result_q      <= result_d;
            reuse_valid_q <= reuse_valid_d;
            reuse_op1_q   <= reuse_op1_d;
            reuse_op2_q   <= reuse_op2_d;
            reuse_sign_q  <= reuse_sign_d;
            reuse_word_q  <= reuse_word_d;
            reuse_quot_q  <= reuse_quot_d;
            reuse_rem_q   <= reuse_rem_d;
        end
    end

    assign bus.in_ready_o      = in_ready_q;
    assign bus.div_req_valid_o = req_valid_q;
    assign bus.div_block_o     = 1'b0;
    assign bus.div_op_1_o      = op1_q;
    assign bus.div_op_2_o      = op2_q;
    assign bus.div_sign_op_1_o = sign_q;
    assign bus.div_sign_op_2_o = sign_q;
    assign bus.out_valid_o     = out_valid_q;
    assign bus.out_result_o    = result_q;
    assign bus.out_tag_o       = tag_q;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the 64-bit multi-cycle divider.
- Accepts RV64M divide and remainder ops (DIV/DIVU/REM/REMU and their W variants) over a valid/ready handshake.
- Resolves divide-by-zero, signed overflow and last-result reuse without starting the divider.
- Otherwise issues to the divider, holds its operands stable for the whole run, captures the result, and presents it downstream; handles flush while the divider is busy.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside each op.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (single clock domain; polarity and synchronicity fixed).
- flush_i  in  1  kill the op in flight and invalidate the reuse entry.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  controller can accept a request.
- in_signed_i  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- in_rem_i  in  1  1 = return remainder, 0 = return quotient.
- in_word_i  in  1  1 = W variant (32-bit operation, result sign-extended).
- in_src1_i  in  64  dividend.
- in_src2_i  in  64  divisor.
- in_tag_i  in  TAG_W  destination tag.
- div_req_valid_o  out  1  start pulse to the divider.
- div_block_o  out  1  divider freeze; constant 0 in this revision.
- div_op_1_o  out  64  divider dividend.
- div_op_2_o  out  64  divider divisor.
- div_sign_op_1_o  out  1  divider dividend sign mode.
- div_sign_op_2_o  out  1  divider divisor sign mode.
- div_quotient_i  in  64  divider quotient.
- div_remainder_i  in  64  divider remainder.
- div_valid_i  in  1  divider result valid (also high while the divider is idle).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_result_o  out  64  result.
- out_tag_o  out  TAG_W  tag of the result.

Behaviour:
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- Reset (rst==0 at clk edge): state IDLE. All outputs 0, except in_ready_o=1 once IDLE. Operand, result and tag registers cleared; reuse entry invalid. Reset mid-operation abandons the op; the divider is reset by the same system reset.
- in_ready_o = 1 only in IDLE. Accept = in_valid_i & in_ready_o & ~flush_i.
- Operand preparation at accept:
  - Word ops: op = signed ? sext(src[31:0]) : zext(src[31:0]).
  - 64-bit ops: op = src unchanged.
  - sign_op_1 = sign_op_2 = in_signed_i.
  - Prepared operands, mode bits and tag are registered.
- Special cases, evaluated on the prepared operands at accept, take priority over the divider path:
  - Divisor == 0: quotient = all ones, remainder = dividend.
  - Signed overflow: signed, dividend = most negative value of the operand width, divisor = -1. Quotient = dividend, remainder = 0.
  - Reuse hit: reuse entry valid and prepared op_1, op_2, signed and word all equal the stored values. Result comes from the stored quotient/remainder (covers DIV followed by REM of the same operands).
  - For any special case: IDLE -> DONE, out_valid_o in the next cycle (latency 1).
- Normal path, accepted in cycle T:
  - T+1: state ISSUE, div_req_valid_o=1 for exactly one cycle. State then goes to WAIT.
  - div_op_*/div_sign_* are driven from the registers and held constant from T+1 until the result is captured. Required: the divider re-samples the sign every cycle.
  - In WAIT, the first cycle with div_valid_i=1 (expected T+67) captures quotient and remainder into the result and reuse registers, marks the reuse entry valid, and moves to DONE.
  - out_valid_o rises at T+68 (latency 68).
- Result selection: rem ? remainder : quotient. If word, the output is sext(selected[31:0]).
- DONE: out_valid_o=1; out_result_o and out_tag_o held stable until out_ready_i=1, then return to IDLE. A new accept is possible in the cycle after the handshake.
- Flush behaviour:
  - In ISSUE or WAIT: go to DRAIN. In DRAIN, wait for div_valid_i=1 while keeping operands held, discard the result, then go to IDLE. The divider cannot be aborted.
  - In DONE: drop out_valid_o and go to IDLE.
  - In any state: invalidate the reuse entry, including a capture in the same cycle.
  - Flush and in_valid_i together in IDLE: no accept.
- div_valid_i is ignored outside WAIT and DRAIN.

Test Plan:
- DIVU src1=100, src2=7, out_ready_i=1 -> one div_req_valid_o pulse at T+1; out_valid_o at T+68; result 14. Then REMU with the same operands -> reuse hit, result 2 at T+1, no div_req_valid_o.
- DIV src1=-7, src2=2 -> result 0xFFFF_FFFF_FFFF_FFFD (-3). REM with src1=-7, src2=3 and a different divisor -> issues to the divider; result 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVW src2[31:0]=0 -> result 0xFFFF_FFFF_FFFF_FFFF in 1 cycle. REMW src1=0x0000_0000_8000_0005, src2=0 -> result 0xFFFF_FFFF_8000_0005.
- DIV src1=0x8000_0000_0000_0000, src2=-1 -> quotient 0x8000_0000_0000_0000. REMW with src1[31:0]=0x8000_0000, src2=-1 -> result 0, in 1 cycle.
- flush_i at T+30 of a normal op -> DRAIN; in_ready_o stays 0 until the divider completes; no out_valid_o. The next identical op is not a reuse hit and issues to the divider.
- Result with out_ready_i held 0 for 10 cycles -> out_valid_o, out_result_o and out_tag_o stable throughout, in_ready_o=0. rst=0 pulsed mid-WAIT -> IDLE next cycle with all outputs cleared.
